// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the UART transmit serializer, its upstream FIFO
// and whatever consumes the serial line and status flags.
interface uart_tx_serializer_if;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    // Environment side: drives enable and FIFO status, watches the line
    modport master (
        output tx_enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    // Serializer side
    modport slave (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls one byte per frame from a registered FIFO
// and shifts it out as start / 8 data bits LSB first / optional parity / stop.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic                 clk,
    input logic                 reset,
    uart_tx_serializer_if.slave bus
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_baudCnt;
    logic [2:0]    r_bitIdx;
    logic          r_stopIdx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_txDone;
    logic          w_rdEn;
    logic          w_baudDone;
    logic          w_parity;
    logic [2:0]    w_nextIdx;

    assign w_baudDone = (r_baudCnt == BAUD_LAST);
    assign w_parity   = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_nextIdx  = r_bitIdx + 3'd1;

    // State register; reset drops any frame in progress back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and the FIFO read strobe, which is only raised from IDLE
    always_comb begin
        w_nextState = r_state;
        w_rdEn      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset && bus.tx_enable && !bus.fifo_empty) begin
                    w_rdEn      = 1'b1;
                    w_nextState = LOAD;
                end
            end
            LOAD:   w_nextState = START;
            START:  if (w_baudDone) w_nextState = DATA;
            DATA: begin
                if (w_baudDone && (r_bitIdx == 3'd7)) begin
                    w_nextState = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (w_baudDone) w_nextState = STOP;
            STOP:   if (w_baudDone && (r_stopIdx == STOP_LAST)) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Baud counter runs only while a bit is on the line and wraps each bit period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baudCnt <= '0;
        end else if ((r_state == START) || (r_state == DATA) ||
                     (r_state == PARITY) || (r_state == STOP)) begin
            r_baudCnt <= w_baudDone ? '0 : r_baudCnt + CW'(1);
        end else begin
            r_baudCnt <= '0;
        end
    end

    // Line driver: the next bit value is loaded at the edge that ends the current bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx      <= 1'b1;
            r_txDone  <= 1'b0;
            r_bitIdx  <= 3'd0;
            r_stopIdx <= 1'b0;
            r_shift   <= 8'h00;
        end else begin
            r_txDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_bitIdx  <= 3'd0;
                    r_stopIdx <= 1'b0;
                end
                LOAD: begin
                    r_shift <= bus.fifo_data;
                    r_tx    <= 1'b0;
                end
                START: begin
                    if (w_baudDone) r_tx <= r_shift[0];
                end
                DATA: begin
                    if (w_baudDone) begin
                        if (r_bitIdx == 3'd7) begin
                            r_tx <= (PARITY_EN != 0) ? w_parity : 1'b1;
                        end else begin
                            r_bitIdx <= w_nextIdx;
                            r_tx     <= r_shift[w_nextIdx];
                        end
                    end
                end
                PARITY: begin
                    if (w_baudDone) r_tx <= 1'b1;
                end
                STOP: begin
                    if (w_baudDone) begin
                        if (r_stopIdx == STOP_LAST) begin
                            r_txDone <= 1'b1;
                        end else begin
                            r_stopIdx <= 1'b1;
                        end
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign bus.fifo_rd_en = w_rdEn;
    assign bus.tx         = r_tx;
    assign bus.tx_busy    = (r_state != IDLE);
    assign bus.tx_done    = r_txDone;
endmodule
